// File: rtl/apb_gpio_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : apb_gpio_arbiter
//  Description : Round-robin arbiter that shares the GPIO APB slave port
//                between N_REQ requesters. It runs one APB transfer at a time
//                (SETUP -> ACCESS), waits on PREADY with a bounded timeout and
//                returns a one-cycle response strobe to the granted requester.
//  Revision    : 1.0  initial release
// ============================================================================
module apb_gpio_arbiter #(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int N_REQ          = 2,
    parameter int TIMEOUT        = 16
) (
    input  logic                             HCLK,
    input  logic                             HRESET,
    input  logic [N_REQ-1:0]                 req_valid,
    input  logic [N_REQ-1:0]                 req_write,
    input  logic [N_REQ*APB_ADDR_WIDTH-1:0]  req_addr,
    input  logic [N_REQ*32-1:0]              req_wdata,
    output logic [N_REQ-1:0]                 req_ready,
    output logic [N_REQ-1:0]                 rsp_valid,
    output logic [31:0]                      rsp_rdata,
    output logic                             rsp_err,
    output logic [APB_ADDR_WIDTH-1:0]        PADDR,
    output logic [31:0]                      PWDATA,
    output logic                             PWRITE,
    output logic                             PSEL,
    output logic                             PENABLE,
    input  logic [31:0]                      PRDATA,
    input  logic                             PREADY,
    input  logic                             PSLVERR
);

    localparam int              c_IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int              c_TW    = $clog2(TIMEOUT) + 1;
    localparam logic [c_IW:0]   c_NREQ  = (c_IW + 1)'(N_REQ);
    localparam logic [c_TW-1:0] c_TLAST = c_TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t            r_state;
    logic [c_IW-1:0]   r_rr_ptr;
    logic [c_IW-1:0]   r_gnt;
    logic [c_TW-1:0]   r_timer;

    logic [2*N_REQ-1:0]        w_dbl;
    logic [N_REQ-1:0]          w_rot;
    logic                      w_found;
    logic [c_IW-1:0]           w_off;
    logic [c_IW:0]             w_sum;
    logic [c_IW-1:0]           w_gnt;
    logic [c_IW:0]             w_rr_inc;
    logic [c_IW-1:0]           w_rr_next;
    logic                      w_sel_write;
    logic [APB_ADDR_WIDTH-1:0] w_sel_addr;
    logic [31:0]               w_sel_wdata;

    // Round-robin search: rotate the request vector so rr_ptr sits at bit 0,
    // take the lowest set bit, then map the offset back to a requester index.
    always_comb begin
        w_dbl   = {req_valid, req_valid};
        w_rot   = N_REQ'(w_dbl >> r_rr_ptr);
        w_found = 1'b0;
        w_off   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_found = 1'b1;
                w_off   = c_IW'(k);
            end
        end
        w_sum = {1'b0, r_rr_ptr} + {1'b0, w_off};
        if (w_sum >= c_NREQ) begin
            w_sum = w_sum - c_NREQ;
        end
        w_gnt = w_sum[c_IW-1:0];
    end

    // Pointer for the next arbitration: the requester just served moves to last place.
    always_comb begin
        w_rr_inc = {1'b0, r_gnt} + (c_IW + 1)'(1);
        if (w_rr_inc == c_NREQ) begin
            w_rr_inc = '0;
        end
        w_rr_next = w_rr_inc[c_IW-1:0];
    end

    // Command fields of the requester that would be granted this cycle.
    always_comb begin
        w_sel_write = 1'b0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_gnt == c_IW'(i)) begin
                w_sel_write = req_write[i];
                w_sel_addr  = req_addr[i*APB_ADDR_WIDTH +: APB_ADDR_WIDTH];
                w_sel_wdata = req_wdata[i*32 +: 32];
            end
        end
    end

    // Accept strobe is only offered while idle; held off during reset so a
    // requester never sees an accept that the reset edge would throw away.
    always_comb begin
        req_ready = '0;
        if ((r_state == S_IDLE) && w_found && !HRESET) begin
            req_ready = N_REQ'(1) << w_gnt;
        end
    end

    // Transfer sequencer with registered APB and response outputs.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_state   <= S_IDLE;
            r_rr_ptr  <= '0;
            r_gnt     <= '0;
            r_timer   <= '0;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= '0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_gnt   <= w_gnt;
                        PWRITE  <= w_sel_write;
                        PADDR   <= w_sel_addr;
                        PWDATA  <= w_sel_write ? w_sel_wdata : 32'd0;
                        PSEL    <= 1'b1;
                        PENABLE <= 1'b0;
                        r_state <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    PENABLE <= 1'b1;
                    r_state <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (PREADY) begin
                        rsp_rdata <= PWRITE ? 32'd0 : PRDATA;
                        rsp_err   <= PSLVERR;
                        rsp_valid <= N_REQ'(1) << r_gnt;
                        PSEL      <= 1'b0;
                        PENABLE   <= 1'b0;
                        r_state   <= S_RESP;
                    end else if (r_timer == c_TLAST) begin
                        // Slave never answered: abort with an error response.
                        rsp_rdata <= 32'd0;
                        rsp_err   <= 1'b1;
                        rsp_valid <= N_REQ'(1) << r_gnt;
                        PSEL      <= 1'b0;
                        PENABLE   <= 1'b0;
                        r_state   <= S_RESP;
                    end else begin
                        r_timer <= r_timer + c_TW'(1);
                    end
                end
                S_RESP: begin
                    r_rr_ptr <= w_rr_next;
                    r_timer  <= '0;
                    r_state  <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_apb_gpio_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_apb_gpio_arbiter
//  Description : Randomised scoreboard bench for apb_gpio_arbiter with an
//                APB slave model and a round-robin reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_apb_gpio_arbiter;

    localparam int AW = 12;
    localparam int N  = 2;
    localparam int TO = 16;

    logic            HCLK = 1'b0;
    logic            HRESET;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_write;
    logic [N*AW-1:0] req_addr;
    logic [N*32-1:0] req_wdata;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    rsp_valid;
    logic [31:0]     rsp_rdata;
    logic            rsp_err;
    logic [AW-1:0]   PADDR;
    logic [31:0]     PWDATA;
    logic            PWRITE;
    logic            PSEL;
    logic            PENABLE;
    logic [31:0]     PRDATA;
    logic            PREADY;
    logic            PSLVERR;

    apb_gpio_arbiter #(
        .APB_ADDR_WIDTH (AW),
        .N_REQ          (N),
        .TIMEOUT        (TO)
    ) dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PWRITE    (PWRITE),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR)
    );

    always #5 HCLK = ~HCLK;

    int cyc = 0;
    always @(posedge HCLK) cyc <= cyc + 1;

    // A requester command together with how the slave will answer it.
    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
        int            waits;
        logic          slverr;
        logic [31:0]   rdata;
    } cmd_t;

    typedef struct {
        int          req;
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } rsp_t;

    typedef struct {
        cmd_t c;
        int   setup_cyc;
    } apb_t;

    cmd_t pend [N];
    bit   has  [N];
    rsp_t rspq [$];
    apb_t apbq [$];

    int checks     = 0;
    int failures   = 0;
    int rr         = 0;
    int busy_until = -1;
    bit drv_rst    = 1'b1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic cmd_t mk(input logic wr, input logic [AW-1:0] addr, input logic [31:0] wdata,
                                input int waits, input logic slverr, input logic [31:0] rdata);
        cmd_t c;
        c.wr = wr; c.addr = addr; c.wdata = wdata;
        c.waits = waits; c.slverr = slverr; c.rdata = rdata;
        return c;
    endfunction

    function automatic cmd_t rnd_cmd();
        cmd_t c;
        c.wr     = 1'($urandom_range(0, 1));
        c.addr   = AW'($urandom);
        c.wdata  = $urandom;
        c.rdata  = $urandom;
        c.slverr = ($urandom_range(0, 3) == 0);
        if ($urandom_range(0, 7) == 0) c.waits = int'($urandom_range(TO - 2, TO + 3));
        else                           c.waits = int'($urandom_range(0, 4));
        return c;
    endfunction

    task automatic load(input int i, input cmd_t c);
        pend[i] = c;
        has[i]  = 1'b1;
    endtask

    function automatic bit any_pending();
        bit a;
        a = 1'b0;
        for (int i = 0; i < N; i++) if (has[i]) a = 1'b1;
        return a;
    endfunction

    // One clock of stimulus: drive pins on the falling edge, then predict
    // the arbitration outcome of the coming rising edge and score it.
    task automatic step();
        logic [N-1:0] exp_rdy;
        int   g;
        int   j;
        int   w;
        bit   tmo;
        rsp_t r;
        apb_t a;
        @(negedge HCLK);
        HRESET = drv_rst;
        if (drv_rst) begin
            rspq.delete();
            apbq.delete();
            rr         = 0;
            busy_until = -1;
        end
        for (int i = 0; i < N; i++) begin
            req_valid[i]             = has[i];
            req_write[i]             = pend[i].wr;
            req_addr[i*AW +: AW]     = pend[i].addr;
            req_wdata[i*32 +: 32]    = pend[i].wdata;
        end
        #1;
        exp_rdy = '0;
        g       = -1;
        if (!drv_rst && cyc > busy_until) begin
            for (int k = 0; k < N; k++) begin
                j = (rr + k) % N;
                if (g < 0 && has[j]) g = j;
            end
        end
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk("req_ready", 64'(req_ready), 64'(exp_rdy));
        if (g >= 0) begin
            tmo        = (pend[g].waits >= TO);
            w          = tmo ? TO - 1 : pend[g].waits;
            r.req      = g;
            r.rdata    = (tmo || pend[g].wr) ? 32'd0 : pend[g].rdata;
            r.err      = tmo ? 1'b1 : pend[g].slverr;
            r.cyc      = cyc + 3 + w;
            rspq.push_back(r);
            a.c         = pend[g];
            a.setup_cyc = cyc + 1;
            apbq.push_back(a);
            busy_until = r.cyc;
            rr         = (g + 1) % N;
            has[g]     = 1'b0;
        end
    endtask

    task automatic run_until_idle(input int budget);
        int n;
        n = 0;
        while ((any_pending() || cyc <= busy_until) && n < budget) begin
            step();
            n++;
        end
        checks++;
        if (n >= budget) begin
            failures++;
            $display("FAIL drain: still busy after %0d cycles, required idle", budget);
        end
    endtask

    // Response monitor: every response strobe must match the oldest expectation.
    initial begin
        rsp_t e;
        forever begin
            @(negedge HCLK);
            if (rsp_valid !== '0) begin
                if (rspq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rsp_unexpected: got rsp_valid=0x%0h, required none (cycle %0d)", rsp_valid, cyc);
                end else begin
                    e = rspq.pop_front();
                    chk("rsp_valid", 64'(rsp_valid), 64'(1) << e.req);
                    chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
                    chk("rsp_err",   64'(rsp_err),   64'(e.err));
                    chk("rsp_cycle", 64'(cyc),       64'(e.cyc));
                    chk("psel_in_resp", 64'({PSEL, PENABLE}), 64'(0));
                end
            end
        end
    end

    // APB slave model: checks the transfer phases and answers after the
    // number of wait states attached to the command.
    initial begin
        apb_t cur;
        int   cnt;
        bit   act;
        bit   rdy;
        act     = 1'b0;
        cnt     = 0;
        PREADY  = 1'b0;
        PRDATA  = '0;
        PSLVERR = 1'b0;
        forever begin
            @(negedge HCLK);
            if (PSEL && !PENABLE) begin
                if (apbq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL apb_setup_unexpected: got PSEL=1 PADDR=0x%0h, required idle bus (cycle %0d)", PADDR, cyc);
                    act = 1'b0;
                end else begin
                    cur = apbq.pop_front();
                    act = 1'b1;
                    cnt = 0;
                    chk("setup_cycle", 64'(cyc),    64'(cur.setup_cyc));
                    chk("setup_paddr", 64'(PADDR),  64'(cur.c.addr));
                    chk("setup_pwrite",64'(PWRITE), 64'(cur.c.wr));
                    chk("setup_pwdata",64'(PWDATA), cur.c.wr ? 64'(cur.c.wdata) : 64'(0));
                end
            end else if (PSEL && PENABLE && act) begin
                chk("access_paddr",  64'(PADDR),  64'(cur.c.addr));
                chk("access_pwrite", 64'(PWRITE), 64'(cur.c.wr));
                chk("access_pwdata", 64'(PWDATA), cur.c.wr ? 64'(cur.c.wdata) : 64'(0));
            end
            if (PSEL && PENABLE && act) begin
                rdy     = (cnt == cur.c.waits);
                PREADY  = rdy;
                PSLVERR = rdy ? cur.c.slverr : 1'($urandom);
                PRDATA  = (rdy && !cur.c.wr) ? cur.c.rdata : $urandom;
                cnt++;
            end else begin
                PREADY  = 1'($urandom);
                PSLVERR = 1'($urandom);
                PRDATA  = $urandom;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // Main stimulus sequence.
    initial begin
        int n;
        HRESET    = 1'b1;
        req_valid = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        for (int i = 0; i < N; i++) begin
            has[i]  = 1'b0;
            pend[i] = mk(1'b0, '0, '0, 0, 1'b0, '0);
        end

        drv_rst = 1'b1;
        repeat (3) step();
        chk("rst_psel",      64'(PSEL),      64'(0));
        chk("rst_penable",   64'(PENABLE),   64'(0));
        chk("rst_pwrite",    64'(PWRITE),    64'(0));
        chk("rst_paddr",     64'(PADDR),     64'(0));
        chk("rst_pwdata",    64'(PWDATA),    64'(0));
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst_rsp_rdata", 64'(rsp_rdata), 64'(0));
        chk("rst_rsp_err",   64'(rsp_err),   64'(0));
        drv_rst = 1'b0;

        // Single write, then single read with nonzero wdata that must not leak.
        load(0, mk(1'b1, 12'h000, 32'h0000_0005, 0, 1'b0, 32'h0));
        run_until_idle(40);
        load(1, mk(1'b0, 12'h034, 32'hDEAD_BEEF, 0, 1'b0, 32'h0100_0005));
        run_until_idle(40);

        // Both requesters continuously valid.
        for (int s = 0; s < 40; s++) begin
            for (int i = 0; i < N; i++)
                if (!has[i]) load(i, mk(1'($urandom_range(0, 1)), AW'($urandom), $urandom,
                                        int'($urandom_range(0, 2)), 1'b0, $urandom));
            step();
        end
        run_until_idle(60);

        // Wait states, timeout, PREADY on the last allowed cycle, slave error.
        load(0, mk(1'b1, 12'h100, 32'h0000_1234, 3, 1'b0, 32'h0));
        run_until_idle(40);
        load(1, mk(1'b0, 12'h200, 32'h0, 1000, 1'b0, 32'h0000_FFFF));
        run_until_idle(60);
        load(0, mk(1'b0, 12'h004, 32'h0, TO - 1, 1'b0, 32'hA5A5_0001));
        run_until_idle(60);
        load(1, mk(1'b0, 12'h00C, 32'h0, TO, 1'b0, 32'hA5A5_0002));
        run_until_idle(60);
        load(0, mk(1'b1, 12'h008, 32'h0000_0077, 2, 1'b1, 32'h0));
        run_until_idle(40);
        load(1, mk(1'b0, 12'h018, 32'h0, 0, 1'b1, 32'h1357_9BDF));
        run_until_idle(40);

        // Reset while requester 1 sits in ACCESS with rr pointing at it.
        load(0, mk(1'b1, 12'h010, 32'h11, 0, 1'b0, 32'h0));
        run_until_idle(40);
        load(1, mk(1'b0, 12'h020, 32'h0, 10, 1'b0, 32'h22));
        n = 0;
        do begin
            step();
            n++;
        end while (!(PSEL && PENABLE) && n < 20);
        chk("reached_access", 64'(PSEL && PENABLE), 64'(1));
        load(0, mk(1'b0, 12'h030, 32'h0, 0, 1'b0, 32'h33));
        drv_rst = 1'b1;
        step();
        drv_rst = 1'b0;
        load(1, mk(1'b1, 12'h040, 32'h44, 0, 1'b0, 32'h0));
        step();
        chk("post_rst_psel",    64'(PSEL),    64'(0));
        chk("post_rst_penable", 64'(PENABLE), 64'(0));
        run_until_idle(60);

        // Randomised traffic with occasional withdrawn requests.
        for (int s = 0; s < 400; s++) begin
            for (int i = 0; i < N; i++) begin
                if (!has[i] && $urandom_range(0, 2) == 0) load(i, rnd_cmd());
                else if (has[i] && $urandom_range(0, 19) == 0) has[i] = 1'b0;
            end
            step();
        end
        run_until_idle(200);
        step();
        chk("rsp_queue_empty", 64'(rspq.size()), 64'(0));
        chk("apb_queue_empty", 64'(apbq.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
